// File: rtl/memory_sub_system_param.sv
// Shared parameters and types for the memory subsystem tag store.
// The optional TAG_MEM_DIRTY_EN build adds per-line dirty tracking.
package memory_sub_system_param;

    localparam int unsigned INDEX_LENGTH = 6;
    localparam int unsigned TAG_LENGTH   = 22;
    localparam int unsigned NUM_WAYS     = 4;
    localparam int unsigned WAY_BITS     = $clog2(NUM_WAYS);
    localparam int unsigned NUM_SETS     = 2 ** INDEX_LENGTH;

    typedef struct packed {
        logic                  valid;
        logic                  dirty;
        logic [TAG_LENGTH-1:0] tag;
    } tag_entry_t;

    typedef enum logic [0:0] {
        IDLE,
        CLEAR
    } tag_fsm_t;

endpackage

// File: rtl/tag_way_bank.sv
// One way of the tag store: NUM_SETS entries, two asynchronous read ports,
// synchronous clear, fill and dirty-mark writes.
module tag_way_bank
    import memory_sub_system_param::*;
(
    input  logic                    clk,
    input  logic [INDEX_LENGTH-1:0] rd_index,
    output tag_entry_t              rd_entry,
    input  logic [INDEX_LENGTH-1:0] probe_index,
    output logic                    probe_valid,
    input  logic                    clr_en,
    input  logic [INDEX_LENGTH-1:0] clr_index,
    input  logic                    wr_en,
    input  logic [INDEX_LENGTH-1:0] wr_index,
    input  tag_entry_t              wr_entry,
    input  logic                    mark_en,
    input  logic [INDEX_LENGTH-1:0] mark_index
);

    tag_entry_t mem [NUM_SETS];

    assign rd_entry    = mem[rd_index];
    assign probe_valid = mem[probe_index].valid;

    // Later statements win: a fill to the same entry overrides a dirty mark.
    always_ff @(posedge clk) begin
        if (mark_en) begin
            mem[mark_index].dirty <= 1'b1;
        end
        if (clr_en) begin
            mem[clr_index] <= '0;
        end else if (wr_en) begin
            mem[wr_index] <= wr_entry;
        end
    end

endmodule

// File: rtl/tag_mem_assoc.sv
// N-way set-associative tag store with round-robin victim selection and a
// flush sweeper. Define TAG_MEM_DIRTY_EN to store and report dirty lines.
module tag_mem_assoc
    import memory_sub_system_param::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    lookup_valid,
    input  logic                    lookup_write,
    input  logic [INDEX_LENGTH-1:0] lookup_index,
    input  logic [TAG_LENGTH-1:0]   lookup_tag,
    output logic                    resp_valid,
    output logic                    hit,
    output logic [WAY_BITS-1:0]     hit_way,
    output logic [WAY_BITS-1:0]     victim_way,
    output logic                    victim_valid,
    output logic [TAG_LENGTH-1:0]   victim_tag,
    output logic                    victim_dirty,
    input  logic                    fill_valid,
    input  logic [INDEX_LENGTH-1:0] fill_index,
    input  logic [WAY_BITS-1:0]     fill_way,
    input  logic [TAG_LENGTH-1:0]   fill_tag,
    input  logic                    fill_dirty,
    input  logic                    flush,
    output logic                    busy
);

    localparam logic [INDEX_LENGTH-1:0] LAST_SET = INDEX_LENGTH'(NUM_SETS - 1);

    tag_fsm_t                state_q, state_d;
    logic [INDEX_LENGTH-1:0] clr_idx_q, clr_idx_d;
    logic [WAY_BITS-1:0]     rr_q [NUM_SETS];

    tag_entry_t          rd_entry [NUM_WAYS];
    tag_entry_t          victim_entry;
    tag_entry_t          fill_entry;
    logic [NUM_WAYS-1:0] match;
    logic [NUM_WAYS-1:0] way_valid;
    logic [NUM_WAYS-1:0] fill_set_valid;
    logic [NUM_WAYS-1:0] mark_en;
    logic                hit_c;
    logic [WAY_BITS-1:0] hit_way_c;
    logic [WAY_BITS-1:0] victim_way_c;
    logic                victim_dirty_c;
    logic                clearing;
    logic                lookup_accept;
    logic                fill_accept;
    logic                fill_dirty_eff;

    assign clearing      = (state_q == CLEAR);
    assign busy          = clearing;
    // A flush in the same cycle as a lookup takes priority over it.
    assign lookup_accept = lookup_valid && !busy && !flush && !reset;
    assign fill_accept   = fill_valid && !busy && !reset;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        unique case (state_q)
            IDLE: begin
                if (flush) begin
                    state_d   = CLEAR;
                    clr_idx_d = '0;
                end
            end
            CLEAR: begin
                if (flush) begin
                    clr_idx_d = '0;
                end else if (clr_idx_q == LAST_SET) begin
                    state_d   = IDLE;
                    clr_idx_d = '0;
                end else begin
                    clr_idx_d = clr_idx_q + 1'b1;
                end
            end
            default: begin
                state_d   = CLEAR;
                clr_idx_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
        tag_way_bank u_bank (
            .clk         (clk),
            .rd_index    (lookup_index),
            .rd_entry    (rd_entry[w]),
            .probe_index (fill_index),
            .probe_valid (fill_set_valid[w]),
            .clr_en      (clearing),
            .clr_index   (clr_idx_q),
            .wr_en       (fill_accept && (fill_way == WAY_BITS'(w))),
            .wr_index    (fill_index),
            .wr_entry    (fill_entry),
            .mark_en     (mark_en[w]),
            .mark_index  (lookup_index)
        );
    end

    // Lowest matching way wins; lowest invalid way beats the round-robin pointer.
    always_comb begin
        match        = '0;
        way_valid    = '0;
        hit_c        = 1'b0;
        hit_way_c    = '0;
        victim_way_c = rr_q[lookup_index];
        for (int w = 0; w < int'(NUM_WAYS); w++) begin
            way_valid[w] = rd_entry[w].valid;
            match[w]     = rd_entry[w].valid && (rd_entry[w].tag == lookup_tag);
        end
        for (int w = int'(NUM_WAYS) - 1; w >= 0; w--) begin
            if (match[w]) begin
                hit_c     = 1'b1;
                hit_way_c = WAY_BITS'(w);
            end
            if (!way_valid[w]) begin
                victim_way_c = WAY_BITS'(w);
            end
        end
        victim_entry = rd_entry[victim_way_c];
    end

`ifdef TAG_MEM_DIRTY_EN
    assign fill_dirty_eff = fill_dirty;
    assign victim_dirty_c = victim_entry.dirty;

    always_comb begin
        mark_en = '0;
        if (lookup_accept && lookup_write && hit_c) begin
            mark_en[hit_way_c] = 1'b1;
        end
    end
`else
    logic unused_dirty;

    assign fill_dirty_eff = 1'b0;
    assign victim_dirty_c = 1'b0;
    assign mark_en        = '0;
    assign unused_dirty   = ^{lookup_write, fill_dirty, victim_entry.dirty};
`endif

    assign fill_entry = '{valid: 1'b1, dirty: fill_dirty_eff, tag: fill_tag};

    always_ff @(posedge clk) begin
        if (clearing) begin
            rr_q[clr_idx_q] <= '0;
        end else if (fill_accept && (&fill_set_valid)) begin
            rr_q[fill_index] <= fill_way + WAY_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !lookup_accept) begin
            resp_valid   <= 1'b0;
            hit          <= 1'b0;
            hit_way      <= '0;
            victim_way   <= '0;
            victim_valid <= 1'b0;
            victim_tag   <= '0;
            victim_dirty <= 1'b0;
        end else begin
            resp_valid   <= 1'b1;
            hit          <= hit_c;
            hit_way      <= hit_way_c;
            victim_way   <= victim_way_c;
            victim_valid <= &way_valid;
            victim_tag   <= victim_entry.tag;
            victim_dirty <= victim_dirty_c;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && lookup_accept) begin
            assert ($onehot0(match))
            else $error("tag_mem_assoc: several ways hit in set %0d", lookup_index);
        end
    end

endmodule

// File: doc/tag_mem_assoc.md
Name: tag_mem_assoc

Overview:
- N-way set-associative tag store for the memory subsystem cache controller; generalises the direct-mapped tag memory.
- Holds per-way valid/dirty/tag and a per-set replacement pointer, and reports hit/miss plus a victim way.
- Contains a flush sequencer that clears the array after reset or on request.
- Sits between the cache controller FSM and the data array; the controller issues lookups and fills.

Parameters:
NUM_WAYS, 4, associativity; power of two, >= 2
INDEX_LENGTH, 6, set index bits; NUM_SETS = 2**INDEX_LENGTH
TAG_LENGTH, 22, stored tag width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
lookup_valid  in  1  lookup request; accepted when lookup_valid && !busy
lookup_write  in  1  lookup is a store; on hit, sets the dirty bit of the hit way
lookup_index  in  INDEX_LENGTH  set to search
lookup_tag  in  TAG_LENGTH  tag to compare
resp_valid  out  1  response strobe, one cycle after an accepted lookup
hit  out  1  tag match in a valid way; qualified by resp_valid
hit_way  out  WAY_BITS  matching way
victim_way  out  WAY_BITS  way to replace on a miss
victim_valid  out  1  victim way currently holds a valid line
victim_tag  out  TAG_LENGTH  tag of the victim line (write-back address)
victim_dirty  out  1  victim line is dirty
fill_valid  in  1  install a tag; ignored while busy
fill_index  in  INDEX_LENGTH  set to fill
fill_way  in  WAY_BITS  way to fill
fill_tag  in  TAG_LENGTH  tag to install
fill_dirty  in  1  initial dirty state of the installed line
flush  in  1  one-cycle pulse; invalidates the whole array
busy  out  1  flush sequencer active

Behaviour:
- WAY_BITS = $clog2(NUM_WAYS).
- Reset: all outputs are 0. The FSM enters CLEAR with clr_idx = 0, and busy = 1 from the first cycle after reset.
- FSM IDLE:
  - flush → CLEAR, clr_idx = 0.
  - A flush arriving in the same cycle as a lookup wins; the lookup is not accepted.
- FSM CLEAR:
  - Each cycle clears valid, dirty and the replacement pointer of set clr_idx, then increments clr_idx.
  - At clr_idx == NUM_SETS-1 the FSM returns to IDLE.
  - busy is high for exactly NUM_SETS cycles.
  - flush while in CLEAR restarts the sweep at 0.
  - reset mid-sweep restarts it at 0.
- Lookup:
  - Latency is 1 cycle. resp_valid and all response fields are registered and held for one cycle only.
  - hit = OR over ways of (valid && tag == lookup_tag). If more than one way matches, the lowest way wins; this is a simulation assertion error.
  - On a hit with lookup_write, the dirty bit of that way is set, visible to the next lookup.
- Victim selection, computed on every lookup:
  - If any way in the set is invalid: the lowest-numbered invalid way, victim_valid = 0.
  - Otherwise: the set's round-robin pointer, victim_valid = 1.
  - victim_tag and victim_dirty come from that way.
  - On a hit, victim fields are still driven; the controller ignores them.
- Fill:
  - Writes valid = 1, tag and dirty into [fill_index][fill_way] at the clock edge.
  - If all ways of the set were valid before the fill, the set's round-robin pointer advances to fill_way+1 mod NUM_WAYS.
- Same-cycle fill and lookup to the same set: the lookup reads pre-fill contents (read-before-write). The fill is not forwarded.
- Same-cycle fill and lookup_write hit to the same way: the fill wins.
- Lookups and fills presented while busy are dropped and produce no resp_valid.

Optional Feature:
TAG_MEM_DIRTY_EN
- Defined: dirty storage is present; lookup_write and fill_dirty are honoured; victim_dirty reflects the stored bit.
- Undefined: no dirty storage; victim_dirty is tied 0; lookup_write and fill_dirty are ignored (write-through cache).

Decomposition:
- Package memory_sub_system_param:
  - Adds NUM_WAYS, WAY_BITS and NUM_SETS.
  - Adds typedef tag_entry_t, a packed struct of valid, dirty and tag[TAG_LENGTH].
  - Adds enum tag_fsm_t {IDLE, CLEAR}.
- Sub-module tag_way_bank:
  - One way's NUM_SETS x tag_entry_t array with asynchronous read and synchronous write/clear.
  - Instantiated NUM_WAYS times via generate.
- Compare, victim and round-robin logic live in the top module.

Test Plan:
- Reset, then hold 64 cycles → busy = 1 for exactly 64 cycles. A lookup at index 5, tag 0x1234 afterwards → hit = 0, victim_way = 0, victim_valid = 0.
- Fill set 5, ways 0-3, with tags 0xA, 0xB, 0xC, 0xD; lookup tag 0xC → resp_valid one cycle later, hit = 1, hit_way = 2.
- Set 5 full; lookup tag 0xE → miss, victim_way = 0, victim_tag = 0xA. Fill way 0 with 0xE; the next miss gives victim_way = 1.
- With TAG_MEM_DIRTY_EN: lookup_write hit on tag 0xB → a later miss whose victim is way 1 reports victim_dirty = 1. Without the macro it reports 0.
- Same-cycle fill (set 5, way 3, tag 0xF) and lookup (set 5, tag 0xF) → hit = 0. A repeat lookup the next cycle → hit = 1, hit_way = 3.
- Pulse flush at sweep index 30 during a second flush → the sweep restarts; busy lasts 64 cycles after the last flush; all sets then miss.
